vp_scale_ctrl: RTL

//  Frame-synchronous configuration controller for the crop + stream-scaler video path (image_cut -> FIFO -> streamScaler).

---
 rtl/vp_scale_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/vp_scale_ctrl.sv
// Frame-synchronous crop/scale configuration controller: shadow regs, commit check, shared divider, vs-aligned swap.
// Optional VP_CFG_FRAME_CNT_EN adds frame_cnt/apply_cnt status outputs.
module vp_scale_ctrl #(
    parameter int H_DISP     = 1280,
    parameter int V_DISP     = 720,
    parameter int POS_WIDTH  = 12,
    parameter int RES_WIDTH  = 11,
    parameter int SCALE_INT  = 4,
    parameter int SCALE_FRAC = 14
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [2:0]                          wr_addr,
    input  logic [POS_WIDTH-1:0]                wr_data,
    input  logic                                commit,
    input  logic                                vs_i,
    output logic [POS_WIDTH-1:0]                start_x,
    output logic [POS_WIDTH-1:0]                start_y,
    output logic [POS_WIDTH-1:0]                end_x,
    output logic [POS_WIDTH-1:0]                end_y,
    output logic [RES_WIDTH-1:0]                in_x_res,
    output logic [RES_WIDTH-1:0]                in_y_res,
    output logic [RES_WIDTH-1:0]                out_x_res,
    output logic [RES_WIDTH-1:0]                out_y_res,
    output logic [SCALE_INT+SCALE_FRAC-1:0]     x_scale,
    output logic [SCALE_INT+SCALE_FRAC-1:0]     y_scale,
    output logic                                start_o,
    output logic                                busy,
    output logic                                pending,
    output logic                                cfg_err
`ifdef VP_CFG_FRAME_CNT_EN
    ,
    output logic [15:0]                         frame_cnt,
    output logic [7:0]                          apply_cnt
`endif
);

    localparam int SCALE_BITS = SCALE_INT + SCALE_FRAC;
    localparam int DEN_W      = RES_WIDTH + 1;
    localparam int NUM_W      = DEN_W + SCALE_FRAC;
    localparam int CNT_W      = $clog2(NUM_W);
    localparam logic [SCALE_BITS-1:0] SCALE_ONE = SCALE_BITS'(1) << SCALE_FRAC;
    localparam logic [SCALE_BITS-1:0] SCALE_MAX = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_DIV_X = 3'd2;
    localparam logic [2:0] S_DIV_Y = 3'd3;
    localparam logic [2:0] S_PEND  = 3'd4;

    logic [2:0]            state;
    logic                  vs_d;
    logic                  vs_edge;

    logic [POS_WIDTH-1:0]  sh_start_x, sh_start_y, sh_end_x, sh_end_y;
    logic [RES_WIDTH-1:0]  sh_out_x, sh_out_y;
    logic [POS_WIDTH-1:0]  wk_start_x, wk_start_y, wk_end_x, wk_end_y;
    logic [RES_WIDTH-1:0]  wk_out_x, wk_out_y;
    logic [RES_WIDTH-1:0]  wk_in_x, wk_in_y;
    logic [SCALE_BITS-1:0] rs_x_scale, rs_y_scale;
    logic                  cfg_bad;

    logic [NUM_W-1:0]      dv_q, q_nx, num_x, num_y;
    logic [DEN_W-1:0]      dv_rem, rem_nx, den;
    logic [DEN_W:0]        rem_sh;
    logic [CNT_W-1:0]      dv_cnt;
    logic                  ge, dv_last;
    logic [SCALE_BITS-1:0] q_sat;

    assign vs_edge = vs_i & ~vs_d;

    assign wk_in_x = RES_WIDTH'(wk_end_x - wk_start_x - POS_WIDTH'(1));
    assign wk_in_y = RES_WIDTH'(wk_end_y - wk_start_y - POS_WIDTH'(1));
    assign cfg_bad = (wk_end_x <= wk_start_x) || (wk_end_y <= wk_start_y) ||
                     (wk_end_x > POS_WIDTH'(H_DISP)) || (wk_end_y > POS_WIDTH'(V_DISP));

    // Restoring divider step: numerator shifts out of dv_q while quotient bits shift in.
    assign num_x   = {DEN_W'(wk_in_x) + DEN_W'(1), {SCALE_FRAC{1'b0}}};
    assign num_y   = {DEN_W'(wk_in_y) + DEN_W'(1), {SCALE_FRAC{1'b0}}};
    assign den     = ((state == S_DIV_Y) ? DEN_W'(wk_out_y) : DEN_W'(wk_out_x)) + DEN_W'(1);
    assign rem_sh  = {dv_rem, dv_q[NUM_W-1]};
    assign ge      = rem_sh >= {1'b0, den};
    assign rem_nx  = ge ? DEN_W'(rem_sh - {1'b0, den}) : DEN_W'(rem_sh);
    assign q_nx    = {dv_q[NUM_W-2:0], ge};
    assign q_sat   = (|q_nx[NUM_W-1:SCALE_BITS]) ? SCALE_MAX : q_nx[SCALE_BITS-1:0];
    assign dv_last = dv_cnt == CNT_W'(NUM_W - 1);

    assign busy    = (state == S_CHECK) || (state == S_DIV_X) || (state == S_DIV_Y);
    assign pending = state == S_PEND;
    assign cfg_err = (state == S_CHECK) && cfg_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d    <= 1'b0;
            start_o <= 1'b0;
        end else begin
            vs_d    <= vs_i;
            start_o <= vs_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_start_x <= '0;
            sh_start_y <= '0;
            sh_end_x   <= POS_WIDTH'(H_DISP);
            sh_end_y   <= POS_WIDTH'(V_DISP);
            sh_out_x   <= RES_WIDTH'(H_DISP - 1);
            sh_out_y   <= RES_WIDTH'(V_DISP - 1);
        end else if (wr_en) begin
            case (wr_addr)
                3'd0:    sh_start_x <= wr_data;
                3'd1:    sh_start_y <= wr_data;
                3'd2:    sh_end_x   <= wr_data;
                3'd3:    sh_end_y   <= wr_data;
                3'd4:    sh_out_x   <= wr_data[RES_WIDTH-1:0];
                3'd5:    sh_out_y   <= wr_data[RES_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wk_start_x <= '0;
            wk_start_y <= '0;
            wk_end_x   <= POS_WIDTH'(H_DISP);
            wk_end_y   <= POS_WIDTH'(V_DISP);
            wk_out_x   <= RES_WIDTH'(H_DISP - 1);
            wk_out_y   <= RES_WIDTH'(V_DISP - 1);
            rs_x_scale <= SCALE_ONE;
            rs_y_scale <= SCALE_ONE;
            dv_q       <= '0;
            dv_rem     <= '0;
            dv_cnt     <= '0;
            start_x    <= '0;
            start_y    <= '0;
            end_x      <= POS_WIDTH'(H_DISP);
            end_y      <= POS_WIDTH'(V_DISP);
            in_x_res   <= RES_WIDTH'(H_DISP - 1);
            in_y_res   <= RES_WIDTH'(V_DISP - 1);
            out_x_res  <= RES_WIDTH'(H_DISP - 1);
            out_y_res  <= RES_WIDTH'(V_DISP - 1);
            x_scale    <= SCALE_ONE;
            y_scale    <= SCALE_ONE;
        end else begin
            // A frame-start swap in PEND happens before a coincident commit takes the new snapshot.
            if (state == S_PEND && vs_edge) begin
                start_x   <= wk_start_x;
                start_y   <= wk_start_y;
                end_x     <= wk_end_x;
                end_y     <= wk_end_y;
                in_x_res  <= wk_in_x;
                in_y_res  <= wk_in_y;
                out_x_res <= wk_out_x;
                out_y_res <= wk_out_y;
                x_scale   <= rs_x_scale;
                y_scale   <= rs_y_scale;
                state     <= S_IDLE;
            end
            case (state)
                S_IDLE, S_PEND: begin
                    if (commit) begin
                        wk_start_x <= sh_start_x;
                        wk_start_y <= sh_start_y;
                        wk_end_x   <= sh_end_x;
                        wk_end_y   <= sh_end_y;
                        wk_out_x   <= sh_out_x;
                        wk_out_y   <= sh_out_y;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cfg_bad) begin
                        state <= S_IDLE;
                    end else begin
                        dv_q   <= num_x;
                        dv_rem <= '0;
                        dv_cnt <= '0;
                        state  <= S_DIV_X;
                    end
                end
                S_DIV_X: begin
                    dv_q   <= q_nx;
                    dv_rem <= rem_nx;
                    dv_cnt <= dv_cnt + CNT_W'(1);
                    if (dv_last) begin
                        rs_x_scale <= q_sat;
                        dv_q       <= num_y;
                        dv_rem     <= '0;
                        dv_cnt     <= '0;
                        state      <= S_DIV_Y;
                    end
                end
                S_DIV_Y: begin
                    dv_q   <= q_nx;
                    dv_rem <= rem_nx;
                    dv_cnt <= dv_cnt + CNT_W'(1);
                    if (dv_last) begin
                        rs_y_scale <= q_sat;
                        state      <= S_PEND;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef VP_CFG_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            apply_cnt <= '0;
        end else begin
            if (vs_edge)
                frame_cnt <= frame_cnt + 16'd1;
            if (state == S_PEND && vs_edge)
                apply_cnt <= apply_cnt + 8'd1;
        end
    end
`endif

endmodule
